// File: rtl/ifm_fetch_if.sv
// ifm_fetch_if: request, SRAM and PE-stream signals of the IFM fetch unit
interface ifm_fetch_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  modport master (
    output req_valid, req_addr, mem_rdata, out_ready,
    input  req_ready, mem_rd_en, mem_addr, out_valid, out_data, out_last
  );
  modport slave (
    input  req_valid, req_addr, mem_rdata, out_ready,
    output req_ready, mem_rd_en, mem_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ifm_fetch_unit.sv
// ifm_fetch_unit: turns controller addresses into SRAM reads, absorbs read latency in a credit-managed FIFO; optional IFM_FETCH_OOB_CHK_EN zero-pads out-of-range reads
module ifm_fetch_unit #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 8,
  parameter int MEM_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int KERNEL     = 3,
  parameter int MEM_DEPTH  = 2 ** ADDR_W
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      en,
  ifm_fetch_if.slave bus,
  output logic      err_oob
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int WIN = KERNEL * KERNEL;
  localparam int BW  = $clog2(WIN) + 1;
  if (FIFO_DEPTH < MEM_LAT + 1 || MEM_DEPTH < 1) begin : g_cfg_err
    $error("ifm_fetch_unit: FIFO_DEPTH must cover MEM_LAT+1 and MEM_DEPTH must be positive");
  end
  logic [DATA_W-1:0]  fifo [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count, inflight;
  logic [MEM_LAT-1:0] lat_v, lat_z;
  logic [BW-1:0]      beat_cnt;
  logic               accept, oob, push, pop;
  // in-flight reads still own a credit, so count them against the FIFO space
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) inflight = inflight + CW'(lat_v[i]);
  end
`ifdef IFM_FETCH_OOB_CHK_EN
  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_DEPTH);
  assign oob = {1'b0, bus.req_addr} >= MEM_LIM;
  // out-of-range flag survives flushes; only reset clears it
  always_ff @(posedge clk)
    if (!reset_n) err_oob <= 1'b0;
    else if (accept && oob) err_oob <= 1'b1;
`else
  assign oob     = 1'b0;
  assign err_oob = 1'b0;
`endif
  assign bus.req_ready = (count + inflight) < CW'(FIFO_DEPTH);
  assign accept        = en & bus.req_valid & bus.req_ready;
  assign bus.mem_rd_en = accept & ~oob;
  assign bus.mem_addr  = bus.req_addr;
  assign push          = en & lat_v[MEM_LAT-1];
  assign bus.out_valid = en & (count != '0);
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.out_data  = bus.out_valid ? fifo[rd_ptr] : '0;
  assign bus.out_last  = bus.out_valid & (beat_cnt == BW'(WIN - 1));
  // latency pipe, FIFO pointers and window counter; en low flushes everything in flight
  always_ff @(posedge clk)
    if (!reset_n || !en) begin
      lat_v    <= '0;
      lat_z    <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      lat_v  <= MEM_LAT'({lat_v, accept});
      lat_z  <= MEM_LAT'({lat_z, oob});
      count  <= count + CW'(push) - CW'(pop);
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      if (pop) beat_cnt <= beat_cnt == BW'(WIN - 1) ? '0 : beat_cnt + BW'(1);
    end
  // FIFO storage; out-of-range slots are written as zero padding
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= lat_z[MEM_LAT-1] ? '0 : bus.mem_rdata;
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(push && count == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_ifm_fetch_unit.sv
// tb_ifm_fetch_unit: scoreboard bench for ifm_fetch_unit at MEM_LAT=1 and MEM_LAT=3
module tb_ifm_fetch_unit;
`ifdef IFM_FETCH_OOB_CHK_EN
  localparam bit OOB = 1'b1;
`else
  localparam bit OOB = 1'b0;
`endif
  typedef struct { logic [7:0] d; int t; } ent_t;
  logic clk = 1'b0, reset_n = 1'b0, en = 1'b0, en3 = 1'b0, err1, err3;
  int   errs = 0, checks = 0, cyc = 0, mb1 = 0, mb3 = 0, acc, cy;
  bit   exact1 = 1'b0, hold1 = 1'b0, hold3 = 1'b0;
  logic [8:0] held1, held3;
  logic [7:0] r1, p3 [3];
  ent_t q1[$], q3[$];
  ent_t e1, e3;
  always #5 clk = ~clk;
  ifm_fetch_if #(.ADDR_W(20), .DATA_W(8)) b1 ();
  ifm_fetch_if #(.ADDR_W(20), .DATA_W(8)) b3 ();
  ifm_fetch_unit #(.MEM_LAT(1), .MEM_DEPTH(256)) u1 (.clk(clk), .reset_n(reset_n), .en(en), .bus(b1.slave), .err_oob(err1));
  ifm_fetch_unit #(.MEM_LAT(3), .MEM_DEPTH(256)) u3 (.clk(clk), .reset_n(reset_n), .en(en3), .bus(b3.slave), .err_oob(err3));
  function automatic logic [7:0] mem_f(input logic [19:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] exp_d(input logic [19:0] a);
    return (OOB && a >= 20'd256) ? 8'h00 : mem_f(a);
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    r1    <= b1.mem_rd_en ? mem_f(b1.mem_addr) : 8'hEE;
    p3[0] <= b3.mem_rd_en ? mem_f(b3.mem_addr) : 8'hEE;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b1.mem_rdata = r1;
  assign b3.mem_rdata = p3[2];
  always @(negedge clk) begin
    if (!reset_n || !en) begin
      if (reset_n) chk("u1_idle_valid", b1.out_valid, 0);
      q1.delete(); mb1 = 0; hold1 = 0;
    end else begin
      if (hold1 && b1.out_valid) chk("u1_hold", {b1.out_last, b1.out_data}, held1);
      hold1 = b1.out_valid && !b1.out_ready;
      held1 = {b1.out_last, b1.out_data};
      if (b1.out_valid && b1.out_ready) begin
        if (q1.size() == 0) chk("u1_spurious_beat", 1, 0);
        else begin
          e1 = q1.pop_front();
          chk("u1_data", b1.out_data, e1.d);
          chk("u1_last", b1.out_last, mb1 == 8);
          if (exact1) chk("u1_latency", cyc - e1.t, 2);
          else chk("u1_latency_min", (cyc - e1.t) >= 2, 1);
          mb1 = (mb1 == 8) ? 0 : mb1 + 1;
        end
      end
      if (b1.req_valid && b1.req_ready) begin
        q1.push_back('{exp_d(b1.req_addr), cyc});
        chk("u1_credit", q1.size() <= 4, 1);
        chk("u1_rd_en", b1.mem_rd_en, !(OOB && b1.req_addr >= 20'd256));
        chk("u1_mem_addr", b1.mem_addr, b1.req_addr);
      end
    end
  end
  always @(negedge clk) begin
    if (!reset_n || !en3) begin
      if (reset_n) chk("u3_idle_valid", b3.out_valid, 0);
      q3.delete(); mb3 = 0; hold3 = 0;
    end else begin
      if (hold3 && b3.out_valid) chk("u3_hold", {b3.out_last, b3.out_data}, held3);
      hold3 = b3.out_valid && !b3.out_ready;
      held3 = {b3.out_last, b3.out_data};
      if (b3.out_valid && b3.out_ready) begin
        if (q3.size() == 0) chk("u3_spurious_beat", 1, 0);
        else begin
          e3 = q3.pop_front();
          chk("u3_data", b3.out_data, e3.d);
          chk("u3_last", b3.out_last, mb3 == 8);
          chk("u3_latency_min", (cyc - e3.t) >= 4, 1);
          mb3 = (mb3 == 8) ? 0 : mb3 + 1;
        end
      end
      if (b3.req_valid && b3.req_ready) begin
        q3.push_back('{exp_d(b3.req_addr), cyc});
        chk("u3_credit", q3.size() <= 4, 1);
      end
    end
  end
  // rmode: 0 ready high, 1 ready toggling, 2 ready random, 3 ready low
  task automatic send1(input logic [19:0] base, input int n, input int rmode, output int used);
    int a = 0;
    used = 0;
    for (int c = 0; c < 200 && a < n; c++) begin
      b1.req_valid = 1'b1;
      b1.req_addr  = base + 20'(a);
      b1.out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? c[0] : rmode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (b1.req_ready) a++;
      used++;
      @(posedge clk); #1;
    end
    b1.req_valid = 1'b0;
    if (a < n) chk("u1_send_timeout", a, n);
  endtask
  task automatic send3(input int n);
    int a = 0;
    for (int c = 0; c < 400 && a < n; c++) begin
      b3.req_valid = 1'b1;
      b3.req_addr  = 20'(a * 37 + 3);
      b3.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (b3.req_ready) a++;
      @(posedge clk); #1;
    end
    b3.req_valid = 1'b0;
    if (a < n) chk("u3_send_timeout", a, n);
  endtask
  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    b1.req_valid = 0; b1.req_addr = '1; b1.out_ready = 0;
    b3.req_valid = 0; b3.req_addr = '1; b3.out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", b1.out_valid, 0);
    chk("rst_out_last", b1.out_last, 0);
    chk("rst_out_data", b1.out_data, 0);
    chk("rst_req_ready", b1.req_ready, 1);
    chk("rst_mem_rd_en", b1.mem_rd_en, 0);
    chk("rst_err_oob", err1, 0);
    chk("rst_u3_req_ready", b3.req_ready, 1);
    @(posedge clk); #1;
    reset_n = 1; en = 1; en3 = 1;
    exact1 = 1;
    send1(20'h0, 9, 0, cy);
    chk("t1_ready_held", cy, 9);
    settle(6);
    exact1 = 0;
    @(negedge clk) chk("t1_drained", q1.size(), 0);
    @(posedge clk); #1;
    b1.out_ready = 0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      b1.req_valid = 1; b1.req_addr = 20'h10 + 20'(acc);
      @(negedge clk);
      if (b1.req_ready) acc++;
      @(posedge clk); #1;
    end
    b1.req_valid = 0;
    @(negedge clk);
    chk("t2_accepted", acc, 4);
    chk("t2_ready_low", b1.req_ready, 0);
    @(posedge clk); #1;
    b1.out_ready = 1;
    settle(8);
    @(negedge clk);
    chk("t2_drained", q1.size(), 0);
    chk("t2_ready_back", b1.req_ready, 1);
    @(posedge clk); #1;
    send1(20'h20, 4, 3, cy);
    send1(20'h30, 12, 1, cy);
    b1.out_ready = 1;
    settle(8);
    @(negedge clk) chk("t3_drained", q1.size(), 0);
    @(posedge clk); #1;
    send1(20'h40, 4, 3, cy);
    en = 0;
    @(negedge clk) chk("t4_valid_low", b1.out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk) chk("t4_ready_after_flush", b1.req_ready, 1);
    @(posedge clk); #1;
    en = 1; b1.out_ready = 1;
    @(negedge clk) chk("t4_no_stale_beat", b1.out_valid, 0);
    @(posedge clk); #1;
    send1(20'h50, 9, 0, cy);
    settle(6);
    @(negedge clk) chk("t4_drained", q1.size(), 0);
    @(posedge clk); #1;
    send3(20);
    b3.out_ready = 1;
    settle(12);
    @(negedge clk) chk("t5_drained", q3.size(), 0);
    @(posedge clk); #1;
    send1(20'h60, 7, 2, cy);
    b1.out_ready = 1;
    settle(8);
    send1(20'hFFFFF, 1, 0, cy);
    settle(4);
    @(negedge clk);
    chk("t6_drained", q1.size(), 0);
    chk("t6_err_set", err1, OOB);
    @(posedge clk); #1;
    en = 0;
    settle(3);
    @(negedge clk) chk("t6_err_sticky", err1, OOB);
    @(posedge clk); #1;
    reset_n = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_err_cleared", err1, 0);
    chk("t6_rst_ready", b1.req_ready, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
